// File: rtl/matvec_engine.sv
// -----------------------------------------------------------------------------
// matvec_engine
//   Matrix-vector multiply engine: C[r] = sum_k A[r][k] * B[k].
//   Operands are fetched over an Avalon-MM read master, one memory word per
//   full row or vector. Word 0 (at base_addr) is B, and words 1..ROWS are the
//   A rows. All ROWS dot products are then accumulated in parallel, one column
//   per cycle. The sums are published on a flat result bus together with a
//   one-cycle done pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle run request, honoured only when idle
//   base_addr           word address of B; A row r is at base_addr+1+r
//   busy                high while fetching or computing
//   done                one-cycle pulse; result is valid from this cycle on
//   result              C[r] at result[r*ACC_WIDTH +: ACC_WIDTH]
//   mem_address         Avalon read address (word units)
//   mem_read            Avalon read request
//   mem_readdata        Avalon read data (element k at [k*DATA_WIDTH +: DATA_WIDTH])
//   mem_readdatavalid   Avalon read data valid
//   mem_waitrequest     Avalon stall
// -----------------------------------------------------------------------------
module matvec_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic                       busy,
  output logic                       done,
  output logic [ROWS*ACC_WIDTH-1:0]  result,
  output logic [ADDR_WIDTH-1:0]      mem_address,
  output logic                       mem_read,
  input  logic [COLS*DATA_WIDTH-1:0] mem_readdata,
  input  logic                       mem_readdatavalid,
  input  logic                       mem_waitrequest
);

  localparam int MEM_WIDTH = COLS * DATA_WIDTH;
  localparam int IDX_W     = $clog2(ROWS + 1);
  localparam int K_W       = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;

  logic [ADDR_WIDTH-1:0]     r_base;
  logic [ADDR_WIDTH-1:0]     r_mem_address;
  logic                      r_mem_read;
  logic                      r_pending;      // a read was accepted and its data is still owed
  logic [IDX_W-1:0]          r_idx;          // next word to capture: 0 = B, r+1 = A row r
  logic [K_W-1:0]            r_k;            // column being accumulated
  logic [MEM_WIDTH-1:0]      r_b;
  logic [MEM_WIDTH-1:0]      r_a   [ROWS];
  logic [ACC_WIDTH-1:0]      r_acc [ROWS];
  logic [ROWS*ACC_WIDTH-1:0] r_result;

  logic                      w_accept;
  logic                      w_capture;
  logic                      w_last_word;
  logic                      w_last_k;
  logic [DATA_WIDTH-1:0]     w_b_el;
  logic [ACC_WIDTH-1:0]      w_acc_next [ROWS];

  // Control decode and next-state logic
  always_comb begin
    w_accept     = (r_state == S_FETCH) && r_mem_read && !mem_waitrequest;
    // Data is taken only while a read is owed. Stray valid pulses are dropped.
    w_capture    = (r_state == S_FETCH) && r_pending && mem_readdatavalid;
    w_last_word  = (r_idx == IDX_W'(ROWS));
    w_last_k     = (r_k == K_W'(COLS - 1));
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start)                    w_state_next = S_FETCH;
      S_FETCH:   if (w_capture && w_last_word) w_state_next = S_COMPUTE;
      S_COMPUTE: if (w_last_k)                 w_state_next = S_DONE;
      S_DONE:                                  w_state_next = S_IDLE;
      default:                                 w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // MAC lanes: every lane uses the same column k of B in a given cycle
  assign w_b_el = r_b[r_k*DATA_WIDTH +: DATA_WIDTH];

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_lane
    logic [DATA_WIDTH-1:0]   w_a_el;
    logic [2*DATA_WIDTH-1:0] w_prod;
    assign w_a_el          = r_a[gr][r_k*DATA_WIDTH +: DATA_WIDTH];
    assign w_prod          = w_a_el * w_b_el;
    // Unsigned sum wraps modulo 2^ACC_WIDTH
    assign w_acc_next[gr]  = r_acc[gr] + ACC_WIDTH'(w_prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base        <= '0;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_pending     <= 1'b0;
      r_idx         <= '0;
      r_k           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      for (int r = 0; r < ROWS; r++) begin
        r_a[r]   <= '0;
        r_acc[r] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base        <= base_addr;
            r_mem_address <= base_addr;
            r_mem_read    <= 1'b1;
            r_pending     <= 1'b0;
            r_idx         <= '0;
            r_k           <= '0;
            for (int r = 0; r < ROWS; r++) r_acc[r] <= '0;
          end
        end
        S_FETCH: begin
          // Only one read is outstanding at a time. The request drops once
          // the read is accepted and is raised again after its data arrives.
          if (w_accept) begin
            r_mem_read <= 1'b0;
            r_pending  <= 1'b1;
          end
          if (w_capture) begin
            r_pending <= 1'b0;
            r_idx     <= r_idx + 1'b1;
            if (r_idx == '0) r_b <= mem_readdata;
            for (int r = 0; r < ROWS; r++)
              if (r_idx == IDX_W'(r + 1)) r_a[r] <= mem_readdata;
            if (!w_last_word) begin
              r_mem_read    <= 1'b1;
              r_mem_address <= r_base + ADDR_WIDTH'(r_idx) + ADDR_WIDTH'(1);
            end
          end
        end
        S_COMPUTE: begin
          for (int r = 0; r < ROWS; r++) r_acc[r] <= w_acc_next[r];
          r_k <= r_k + 1'b1;
          // The final sums are published on the same edge that enters DONE,
          // so result is already valid while done is high.
          if (w_last_k)
            for (int r = 0; r < ROWS; r++)
              r_result[r*ACC_WIDTH +: ACC_WIDTH] <= w_acc_next[r];
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_FETCH) || (r_state == S_COMPUTE);
  assign done        = (r_state == S_DONE);
  assign result      = r_result;
  assign mem_address = r_mem_address;
  assign mem_read    = r_mem_read;

endmodule

// File: tb/tb_matvec_engine.sv
// -----------------------------------------------------------------------------
// tb_matvec_engine
//   Scoreboard bench with two engines. u0 uses the default geometry. u1 uses
//   ROWS=4, COLS=16 and ACC_WIDTH=16, so its sums can wrap. Stimulus tasks
//   fill a word-addressed memory and push reference results into a queue.
//   Monitors pop that queue on each done pulse.
// -----------------------------------------------------------------------------
module tb_matvec_engine;

  localparam int R0 = 8, C0 = 8, A0 = 24, MW0 = 64;
  localparam int R1 = 4, C1 = 16, A1 = 16, MW1 = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic                start0, busy0, done0, rd0, wait0, rdv0, stray0, rdv0_in;
  logic [31:0]         base0, addr0;
  logic [R0*A0-1:0]    res0;
  logic [MW0-1:0]      rdata0;

  logic                start1, busy1, done1, rd1, wait1, rdv1;
  logic [31:0]         base1, addr1;
  logic [R1*A1-1:0]    res1;
  logic [MW1-1:0]      rdata1;

  assign rdv0_in = rdv0 | stray0;

  matvec_engine #(.ROWS(R0), .COLS(C0), .DATA_WIDTH(8), .ACC_WIDTH(A0), .ADDR_WIDTH(32)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .base_addr(base0),
    .busy(busy0), .done(done0), .result(res0),
    .mem_address(addr0), .mem_read(rd0), .mem_readdata(rdata0),
    .mem_readdatavalid(rdv0_in), .mem_waitrequest(wait0)
  );

  matvec_engine #(.ROWS(R1), .COLS(C1), .DATA_WIDTH(8), .ACC_WIDTH(A1), .ADDR_WIDTH(32)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .base_addr(base1),
    .busy(busy1), .done(done1), .result(res1),
    .mem_address(addr1), .mem_read(rd1), .mem_readdata(rdata1),
    .mem_readdatavalid(rdv1), .mem_waitrequest(wait1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit stall_mode = 1'b0;
  int rdcnt1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [MW0-1:0] mem0 [int];
  logic [MW1-1:0] mem1 [int];

  typedef struct {
    logic [R0*A0-1:0] exp;
    int               cyc;
    bit               lat;
  } sb0_t;
  sb0_t             q0[$];
  logic [R1*A1-1:0] q1[$];

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference model: plain dot products over the memory image, reduced mod 2^ACC
  function automatic logic [R0*A0-1:0] ref0(input int base);
    logic [R0*A0-1:0] v;
    logic [MW0-1:0]   bw, aw;
    longint           s;
    v  = '0;
    bw = mem0[base];
    for (int r = 0; r < R0; r++) begin
      aw = mem0[base + 1 + r];
      s  = 0;
      for (int k = 0; k < C0; k++) s += longint'(aw[k*8 +: 8]) * longint'(bw[k*8 +: 8]);
      v[r*A0 +: A0] = A0'(s % (longint'(1) << A0));
    end
    return v;
  endfunction

  function automatic logic [R1*A1-1:0] ref1(input int base);
    logic [R1*A1-1:0] v;
    logic [MW1-1:0]   bw, aw;
    longint           s;
    v  = '0;
    bw = mem1[base];
    for (int r = 0; r < R1; r++) begin
      aw = mem1[base + 1 + r];
      s  = 0;
      for (int k = 0; k < C1; k++) s += longint'(aw[k*8 +: 8]) * longint'(bw[k*8 +: 8]);
      v[r*A1 +: A1] = A1'(s % (longint'(1) << A1));
    end
    return v;
  endfunction

  task automatic fill0_pattern(input int base);
    logic [MW0-1:0] w;
    for (int k = 0; k < C0; k++) w[k*8 +: 8] = 8'd1;
    mem0[base] = w;
    for (int r = 0; r < R0; r++) begin
      for (int k = 0; k < C0; k++) w[k*8 +: 8] = 8'(r);
      mem0[base + 1 + r] = w;
    end
  endtask

  task automatic fill0_rand(input int base);
    for (int i = 0; i <= R0; i++) mem0[base + i] = {$urandom, $urandom};
  endtask

  task automatic fill0_const(input int base, input logic [7:0] val);
    logic [MW0-1:0] w;
    for (int k = 0; k < C0; k++) w[k*8 +: 8] = val;
    for (int i = 0; i <= R0; i++) mem0[base + i] = w;
  endtask

  task automatic fill1_rand(input int base);
    for (int i = 0; i <= R1; i++) mem1[base + i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic fill1_const(input int base, input logic [7:0] val);
    logic [MW1-1:0] w;
    for (int k = 0; k < C1; k++) w[k*8 +: 8] = val;
    for (int i = 0; i <= R1; i++) mem1[base + i] = w;
  endtask

  // Callers invoke these at #1 after a rising edge
  task automatic go0(input int base, input bit lat);
    sb0_t e;
    e.exp  = ref0(base);
    e.lat  = lat;
    e.cyc  = cyc;
    q0.push_back(e);
    base0  = 32'(base);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
  endtask

  task automatic go1(input int base);
    q1.push_back(ref1(base));
    rdcnt1 = 0;
    base1  = 32'(base);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait0_drain();
    int n = 0;
    while (q0.size() != 0 && n < 600) begin @(posedge clk); #1; n++; end
    chk("u0_done_timeout", 256'(q0.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait1_drain();
    int n = 0;
    while (q1.size() != 0 && n < 600) begin @(posedge clk); #1; n++; end
    chk("u1_done_timeout", 256'(q1.size()), 0);
    @(posedge clk); #1;
  endtask

  // Avalon slave for u0: optional random waitrequest and read-data delay
  initial begin : resp0
    int ns, d, a;
    wait0 = 1'b0; rdv0 = 1'b0; rdata0 = '0;
    forever begin
      if (!(rst_n === 1'b1 && rd0 === 1'b1)) begin
        @(posedge clk); #1;
      end else begin
        a  = int'(addr0);
        ns = stall_mode ? int'($urandom_range(0, 5)) : 0;
        if (ns > 0) begin
          wait0 = 1'b1;
          repeat (ns) begin
            @(posedge clk); #1;
            chk("stall_read_held", 256'(rd0), 1);
            chk("stall_addr_held", 256'(addr0), 256'(a));
          end
          wait0 = 1'b0;
        end
        @(posedge clk); #1;
        chk("read_drops_after_accept", 256'(rd0), 0);
        d = stall_mode ? int'($urandom_range(1, 4)) : 1;
        repeat (d - 1) begin @(posedge clk); #1; end
        rdv0   = 1'b1;
        rdata0 = mem0[a];
        @(posedge clk); #1;
        rdv0   = 1'b0;
      end
    end
  end

  // Zero-wait Avalon slave for u1. Every u1 run uses base 0x100.
  initial begin : resp1
    int a;
    wait1 = 1'b0; rdv1 = 1'b0; rdata1 = '0;
    forever begin
      if (!(rst_n === 1'b1 && rd1 === 1'b1)) begin
        @(posedge clk); #1;
      end else begin
        a = int'(addr1);
        chk("u1_addr_range", 256'(addr1 >= 32'h100 && addr1 <= 32'h104), 1);
        rdcnt1++;
        @(posedge clk); #1;
        rdv1   = 1'b1;
        rdata1 = mem1[a];
        @(posedge clk); #1;
        rdv1   = 1'b0;
      end
    end
  end

  initial begin : mon0
    sb0_t e;
    forever begin
      @(posedge clk); #1;
      if (done0 === 1'b1) begin
        chk("u0_done_expected", 256'(q0.size() != 0), 1);
        chk("u0_busy_low_at_done", 256'(busy0), 0);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("u0_result", 256'(res0), 256'(e.exp));
          // Start cycle and done cycle span 28 cycles inclusive
          if (e.lat) chk("u0_latency", 256'(cyc - e.cyc), 27);
        end
      end
    end
  end

  initial begin : mon1
    logic [R1*A1-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (done1 === 1'b1) begin
        chk("u1_done_expected", 256'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("u1_result", 256'(res1), 256'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [R0*A0-1:0] prev;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; base0 = '0; base1 = '0; stray0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",   256'(busy0), 0);
    chk("reset_done",   256'(done0), 0);
    chk("reset_read",   256'(rd0),   0);
    chk("reset_addr",   256'(addr0), 0);
    chk("reset_result", 256'(res0),  0);
    chk("reset_u1",     256'({busy1, done1, rd1, addr1, res1}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // B = all 1, A row r = all r, zero-wait memory
    fill0_pattern(32'h10);
    go0(32'h10, 1'b1);
    wait0_drain();
    for (int r = 0; r < R0; r++) chk("t1_lane", 256'(res0[r*A0 +: A0]), 256'(8 * r));

    // All elements 255: largest sum, no wrap at 24 bits
    fill0_const(32'h40, 8'hFF);
    go0(32'h40, 1'b1);
    wait0_drain();
    chk("t2_lane0_max", 256'(res0[0 +: A0]), 520200);

    // Random operands, zero-wait memory
    for (int t = 0; t < 4; t++) begin
      fill0_rand(32'h80 + 16 * t);
      go0(32'h80 + 16 * t, 1'b1);
      wait0_drain();
    end

    // Random stalls and read-data delays
    stall_mode = 1'b1;
    go0(32'h10, 1'b0);
    wait0_drain();
    for (int t = 0; t < 3; t++) begin
      fill0_rand(32'h200 + 16 * t);
      go0(32'h200 + 16 * t, 1'b0);
      wait0_drain();
    end
    stall_mode = 1'b0;

    // Start during FETCH and on the done cycle must be ignored
    fill0_rand(32'h300);
    fill0_rand(32'h320);
    go0(32'h300, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    base0 = 32'h320; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (done0 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk("t4_done_seen", 256'(done0), 1);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("t4_start_on_done_ignored", 256'(busy0), 0);
    repeat (40) @(posedge clk);
    #1;
    chk("t4_stays_idle", 256'(busy0), 0);
    chk("t4_queue_empty", 256'(q0.size()), 0);
    prev = res0;
    go0(32'h320, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_result_held", 256'(res0), 256'(prev));
    wait0_drain();

    // ROWS=4, COLS=16, base 0x100: random operands, then an all-255 wrap
    for (int t = 0; t < 3; t++) begin
      fill1_rand(32'h100);
      go1(32'h100);
      wait1_drain();
      chk("t6_read_count", 256'(rdcnt1), 5);
    end
    fill1_const(32'h100, 8'hFF);
    go1(32'h100);
    wait1_drain();
    chk("t6_wrap_lane3", 256'(res1[3*A1 +: A1]), 57360);

    // Asynchronous reset during COMPUTE, followed by a stray valid pulse
    fill0_rand(32'h400);
    go0(32'h400, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_in_compute", 256'(busy0), 1);
    chk("t5_not_reading", 256'(rd0), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_busy",   256'(busy0), 0);
    chk("t5_abort_done",   256'(done0), 0);
    chk("t5_abort_result", 256'(res0),  0);
    chk("t5_abort_addr",   256'(addr0), 0);
    q0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    stray0 = 1'b1;
    @(posedge clk); #1;
    stray0 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("t5_idle_busy",   256'(busy0), 0);
    chk("t5_idle_read",   256'(rd0),   0);
    chk("t5_idle_result", 256'(res0),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
